// File: rtl/instr_fifo_pkg.sv
// ============================================================================
// Module : instr_fifo_pkg
// Brief  : Shared widths and default geometry for the instruction buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fifo_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 64;
  localparam int DP_DEFAULT = 4;
  localparam int AW_DEFAULT = 2;

endpackage : instr_fifo_pkg

`default_nettype wire

// File: rtl/gen_dffr.sv
// ============================================================================
// Module : gen_dffr
// Brief  : Common enabled flop with asynchronous active-low reset to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gen_dffr #(
  parameter int DW = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : gen_dffr

`default_nettype wire

// File: rtl/instr_fifo_ptr.sv
// ============================================================================
// Module : instr_fifo_ptr
// Brief  : Read/write pointer pair with wrap bit, push/pop qualification and
//          full/empty generation for the instruction buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fifo_ptr
  import instr_fifo_pkg::*;
#(
  parameter int DP = DP_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  input  logic          flush_i,
  output logic          push_o,
  output logic [AW-1:0] wr_idx_o,
  output logic [AW-1:0] rd_idx_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] occ;
  logic        pop;

  // Flags come from registered pointers only, so a push is never visible
  // at the head in the same cycle it is written.
  assign empty_o = (rd_ptr_q == wr_ptr_q);
  assign full_o  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                   (rd_ptr_q[AW] != wr_ptr_q[AW]);

  assign push_o = push_req_i & ~full_o  & ~flush_i;
  assign pop    = pop_req_i  & ~empty_o & ~flush_i;

  assign wr_idx_o = wr_ptr_q[AW-1:0];
  assign rd_idx_o = rd_ptr_q[AW-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_o) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  gen_dffr #(.DW(AW+1)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .d_i    (wr_ptr_d),
    .q_o    (wr_ptr_q)
  );

  gen_dffr #(.DW(AW+1)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .d_i    (rd_ptr_d),
    .q_o    (rd_ptr_q)
  );

  // Modular difference exceeds DP on both overflow and underflow.
  assign occ = wr_ptr_q - rd_ptr_q;

  a_occ_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ <= (AW+1)'(DP));

endmodule : instr_fifo_ptr

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module : instr_fifo
// Brief  : Circular {pc, instr} buffer between fetch and decode with
//          backpressure via instrFifo_full and single-cycle flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int DP = DP_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               fetch_decode_vaild,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic               instrFifo_full,
  input  logic               decode_ready,
  output logic               instrFifo_empty,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  input  logic               flush
);

  logic               push;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;
  logic [INSTR_W-1:0] instr_q [DP];
  logic [PC_W-1:0]    pc_q    [DP];

  instr_fifo_ptr #(.DP(DP), .AW(AW)) u_ptr (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .push_req_i (fetch_decode_vaild),
    .pop_req_i  (decode_ready),
    .flush_i    (flush),
    .push_o     (push),
    .wr_idx_o   (wr_idx),
    .rd_idx_o   (rd_idx),
    .full_o     (instrFifo_full),
    .empty_o    (instrFifo_empty)
  );

  // Entries are never cleared on pop or flush; pointers alone define validity.
  for (genvar i = 0; i < DP; i++) begin : g_entry
    logic we;
    assign we = push && (wr_idx == AW'(i));

    gen_dffr #(.DW(INSTR_W)) u_instr (
      .clk_i  (CLK),
      .rst_ni (RSTn),
      .en_i   (we),
      .d_i    (instr),
      .q_o    (instr_q[i])
    );

    gen_dffr #(.DW(PC_W)) u_pc (
      .clk_i  (CLK),
      .rst_ni (RSTn),
      .en_i   (we),
      .d_i    (pc),
      .q_o    (pc_q[i])
    );
  end

  assign instr_out = instr_q[rd_idx];
  assign pc_out    = pc_q[rd_idx];

endmodule : instr_fifo

`default_nettype wire

// File: tb/tb_instr_fifo.sv
// ============================================================================
// Module : tb_instr_fifo
// Brief  : Scenario and randomized bench for instr_fifo against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fifo;

  localparam int DP = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        fetch_decode_vaild = 1'b0;
  logic        decode_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  logic        instrFifo_full;
  logic        instrFifo_empty;
  logic [31:0] instr_out;
  logic [63:0] pc_out;

  int   vectors = 0;
  int   errs    = 0;
  ent_t mq[$];

  always #5 CLK = ~CLK;

  instr_fifo #(.DP(DP), .AW(2)) dut (
    .CLK                (CLK),
    .RSTn               (RSTn),
    .fetch_decode_vaild (fetch_decode_vaild),
    .instr              (instr),
    .pc                 (pc),
    .instrFifo_full     (instrFifo_full),
    .decode_ready       (decode_ready),
    .instrFifo_empty    (instrFifo_empty),
    .instr_out          (instr_out),
    .pc_out             (pc_out),
    .flush              (flush)
  );

  // Drives one cycle of inputs, then advances the queue model by the
  // accept rules: flush wins, pop needs an entry, push needs a free slot.
  task automatic step(input logic v, input logic r, input logic f,
                      input logic [31:0] i_w, input logic [63:0] p_w);
    bit do_push, do_pop;
    fetch_decode_vaild = v;
    decode_ready       = r;
    flush              = f;
    instr              = i_w;
    pc                 = p_w;
    @(posedge CLK);
    do_push = v && (mq.size() < DP) && !f;
    do_pop  = r && (mq.size() > 0) && !f;
    if (RSTn) begin
      if (f) begin
        mq.delete();
      end else begin
        if (do_pop)  mq.delete(0);
        if (do_push) mq.push_back({p_w, i_w});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 RSTn = 1'b0;
    fetch_decode_vaild = 1'b1;
    decode_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      vectors++;
      if (instrFifo_empty !== 1'b1 || instrFifo_full !== 1'b0 ||
          instr_out !== 32'h0 || pc_out !== 64'h0) begin
        errs++;
        $display("FAIL reset_hold cyc=%0d got e=%b f=%b i=%h p=%h exp e=1 f=0 i=0 p=0",
                 k, instrFifo_empty, instrFifo_full, instr_out, pc_out);
      end
    end
    RSTn = 1'b1;
    mq.delete();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
      vectors++;
      if (instrFifo_empty !== 1'b1 || instrFifo_full !== 1'b0 ||
          instr_out !== 32'h0 || pc_out !== 64'h0) begin
        errs++;
        $display("FAIL reset_idle cyc=%0d got e=%b f=%b i=%h p=%h exp e=1 f=0 i=0 p=0",
                 k, instrFifo_empty, instrFifo_full, instr_out, pc_out);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_ins [5];
    exp_ins = '{32'h13, 32'h14, 32'h15, 32'h16, 32'hDEAD_BEEF};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h13 + 32'(k), 64'h8000_0000 + 64'(4 * k));
      vectors++;
      if (instrFifo_full !== (k == 3) || instrFifo_empty !== 1'b0) begin
        errs++;
        $display("FAIL fill_flags k=%0d got f=%b e=%b exp f=%b e=0",
                 k, instrFifo_full, instrFifo_empty, k == 3);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 64'h8000_0010);
      vectors++;
      if (instrFifo_full !== 1'b1 || instr_out !== exp_ins[0]) begin
        errs++;
        $display("FAIL fill_held got f=%b i=%h exp f=1 i=%h",
                 instrFifo_full, instr_out, exp_ins[0]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 64'h8000_0010);
    vectors++;
    if (instrFifo_full !== 1'b0 || instr_out !== exp_ins[1]) begin
      errs++;
      $display("FAIL fill_first_pop got f=%b i=%h exp f=0 i=%h",
               instrFifo_full, instr_out, exp_ins[1]);
    end
    step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 64'h8000_0010);
    vectors++;
    if (instrFifo_full !== 1'b1) begin
      errs++;
      $display("FAIL fill_refill got f=%b exp f=1", instrFifo_full);
    end
    for (int k = 1; k < 5; k++) begin
      vectors++;
      if (instr_out !== exp_ins[k] || instrFifo_empty !== 1'b0) begin
        errs++;
        $display("FAIL fill_drain k=%0d got i=%h e=%b exp i=%h e=0",
                 k, instr_out, instrFifo_empty, exp_ins[k]);
      end
      step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    end
    vectors++;
    if (instrFifo_empty !== 1'b1 || mq.size() != 0) begin
      errs++;
      $display("FAIL fill_end got e=%b exp e=1", instrFifo_empty);
    end
  endtask

  task automatic test_stream();
    logic [63:0] base;
    base = 64'h0000_4000;
    step(1'b1, 1'b0, 1'b0, 32'h100, base);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h100 + 32'(k), base + 64'(4 * k));
      vectors++;
      if (instrFifo_empty !== 1'b0 || instrFifo_full !== 1'b0 ||
          pc_out !== base + 64'(4 * k)) begin
        errs++;
        $display("FAIL stream k=%0d got e=%b f=%b p=%h exp e=0 f=0 p=%h",
                 k, instrFifo_empty, instrFifo_full, pc_out, base + 64'(4 * k));
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic test_simul();
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 1'b0, 32'h200 + 32'(k), 64'h8000_0000 + 64'(4 * k));
    step(1'b1, 1'b1, 1'b0, 32'h2FF, 64'h7777_0000);
    vectors++;
    if (instrFifo_full !== 1'b0 || pc_out !== 64'h8000_0004) begin
      errs++;
      $display("FAIL simul_full got f=%b p=%h exp f=0 p=8000_0004",
               instrFifo_full, pc_out);
    end
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (instrFifo_empty !== 1'b0 || pc_out !== 64'h8000_0000 + 64'(4 * k)) begin
        errs++;
        $display("FAIL simul_drain k=%0d got e=%b p=%h exp e=0 p=%h",
                 k, instrFifo_empty, pc_out, 64'h8000_0000 + 64'(4 * k));
      end
      step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    end
    vectors++;
    if (instrFifo_empty !== 1'b1) begin
      errs++;
      $display("FAIL simul_rejected got e=%b exp e=1", instrFifo_empty);
    end
    step(1'b1, 1'b1, 1'b0, 32'h300, 64'h0000_5000);
    vectors++;
    if (instrFifo_empty !== 1'b0 || pc_out !== 64'h0000_5000 || instr_out !== 32'h300) begin
      errs++;
      $display("FAIL simul_empty got e=%b p=%h i=%h exp e=0 p=5000 i=300",
               instrFifo_empty, pc_out, instr_out);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b0, 32'h400 + 32'(k), 64'h6000_0000 + 64'(4 * k));
    step(1'b1, 1'b1, 1'b1, 32'h499, 64'h9000_0000);
    vectors++;
    if (instrFifo_empty !== 1'b1 || instrFifo_full !== 1'b0) begin
      errs++;
      $display("FAIL flush_flags got e=%b f=%b exp e=1 f=0", instrFifo_empty, instrFifo_full);
    end
    step(1'b1, 1'b0, 1'b0, 32'h4AA, 64'hA000_0000);
    vectors++;
    if (instrFifo_empty !== 1'b0 || pc_out !== 64'hA000_0000) begin
      errs++;
      $display("FAIL flush_after got e=%b p=%h exp e=0 p=A000_0000", instrFifo_empty, pc_out);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    vectors++;
    if (instrFifo_empty !== 1'b1) begin
      errs++;
      $display("FAIL flush_drain got e=%b exp e=1", instrFifo_empty);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 32'h500, 64'hB000_0000);
    step(1'b1, 1'b0, 1'b0, 32'h501, 64'hB000_0004);
    fetch_decode_vaild = 1'b0;
    vectors++;
    if (instrFifo_empty !== 1'b0 || pc_out !== 64'hB000_0000) begin
      errs++;
      $display("FAIL areset_pre got e=%b p=%h exp e=0 p=B000_0000", instrFifo_empty, pc_out);
    end
    #2 RSTn = 1'b0;
    #1;
    mq.delete();
    vectors++;
    if (instrFifo_empty !== 1'b1 || instrFifo_full !== 1'b0 ||
        pc_out !== 64'h0 || instr_out !== 32'h0) begin
      errs++;
      $display("FAIL areset_mid got e=%b f=%b p=%h i=%h exp e=1 f=0 p=0 i=0",
               instrFifo_empty, instrFifo_full, pc_out, instr_out);
    end
    @(posedge CLK);
    #1 RSTn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h502, 64'hC000_0000);
    vectors++;
    if (instrFifo_empty !== 1'b0 || pc_out !== 64'hC000_0000) begin
      errs++;
      $display("FAIL areset_resume got e=%b p=%h exp e=0 p=C000_0000", instrFifo_empty, pc_out);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom, {$urandom, $urandom});
      vectors++;
      if (instrFifo_empty !== (mq.size() == 0) || instrFifo_full !== (mq.size() == DP)) begin
        errs++;
        $display("FAIL rand_flags k=%0d got e=%b f=%b exp e=%b f=%b",
                 k, instrFifo_empty, instrFifo_full, mq.size() == 0, mq.size() == DP);
      end
      if (mq.size() > 0) begin
        vectors++;
        if ({pc_out, instr_out} !== mq[0]) begin
          errs++;
          $display("FAIL rand_head k=%0d got p=%h i=%h exp p=%h i=%h",
                   k, pc_out, instr_out, mq[0].pc, mq[0].ins);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_simul();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_instr_fifo

`default_nettype wire
